// File: rtl/ram_burst_reader_pkg.sv
// Shared definitions for the RAM burst reader and its skid buffer.
// The credit helper is kept here so any RAM reader that reuses the skid buffer applies the same rule.
package ram_burst_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;

  // A new read may issue only if, counting this cycle's pop, the word it returns still fits.
  function automatic logic has_credit(input logic [1:0] occupancy,
                                      input logic       inflight,
                                      input logic       pop);
    logic [2:0] used;
    used = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
    return used < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/ram_read_skid_buffer.sv
// Two-entry FIFO that absorbs RAM read data while the consumer stalls.
// The output is the head register, so data and valid are stable for the whole stall.
module ram_read_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [1:0]            count;
  logic                  pop_ok;

  assign pop_ok     = pop && (count != 2'd0);
  assign head_data  = head;
  assign head_valid = (count != 2'd0);
  assign occupancy  = count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy holds; the new word lands behind whatever is still queued.
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge Clock) disable iff (Reset)
    !(push && !pop_ok && count == 2'd2));

endmodule

// File: rtl/ram_burst_reader.sv
// Streams a burst of consecutive RAM words onto a valid/ready port at one word per cycle.
// Reads are credit-limited so a stalled consumer never loses a word already requested from the RAM.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [ADDR_WIDTH-1:0] iBaseAddress,
  input  logic [LEN_WIDTH-1:0]  iLength,
  output logic                  oBusy,
  output logic                  oReadEnable,
  output logic [ADDR_WIDTH-1:0] oReadAddress,
  input  logic [DATA_WIDTH-1:0] iReadData,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic                  oDone
);
  import ram_burst_reader_pkg::*;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  issue;
  logic                  pop;
  logic                  start;
  logic [1:0]            occupancy;

  // oReadEnable doubles as the inflight flag: data for it arrives at the next edge.
  assign pop   = oValid && iReady;
  assign start = (state == S_IDLE) && iStart;
  assign oBusy = (state != S_IDLE);
  assign oDone = (state == S_DONE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        if (iStart) state_next = (iLength == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        issue = (remaining != '0) && has_credit(occupancy, oReadEnable, pop);
        if (issue && remaining == LEN_WIDTH'(1)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Finished once the final word leaves and nothing else is buffered or returning.
        if (pop && occupancy == 2'd1 && !oReadEnable) state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr         <= '0;
      remaining    <= '0;
      oReadEnable  <= 1'b0;
      oReadAddress <= '0;
    end else begin
      oReadEnable <= issue;
      if (start) begin
        addr      <= iBaseAddress;
        remaining <= iLength;
      end else if (issue) begin
        oReadAddress <= addr;
        addr         <= addr + ADDR_WIDTH'(1);
        remaining    <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  ram_read_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (oReadEnable),
    .push_data (iReadData),
    .pop       (pop),
    .head_data (oData),
    .head_valid(oValid),
    .occupancy (occupancy)
  );

  a_done_empty: assert property (@(posedge Clock) disable iff (Reset)
    (state == S_DONE) |-> (occupancy == 2'd0 && !oReadEnable));

endmodule

// File: tb/tb_ram_burst_reader.sv
module tb_ram_burst_reader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iStart;
  logic [15:0] iBaseAddress;
  logic [7:0]  iLength;
  logic        oBusy;
  logic        oReadEnable;
  logic [15:0] oReadAddress;
  logic [7:0]  iReadData;
  logic [7:0]  oData;
  logic        oValid;
  logic        iReady;
  logic        oDone;
  logic [7:0]  junk;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  ram_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .LEN_WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iBaseAddress(iBaseAddress),
    .iLength(iLength), .oBusy(oBusy), .oReadEnable(oReadEnable), .oReadAddress(oReadAddress),
    .iReadData(iReadData), .oData(oData), .oValid(oValid), .iReady(iReady), .oDone(oDone)
  );

  function automatic logic [7:0] ram_val(input logic [15:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  always_ff @(posedge Clock) junk <= 8'($urandom);
  assign iReadData = oReadEnable ? ram_val(oReadAddress) : junk;

  task automatic start_burst(input logic [15:0] base, input logic [7:0] len);
    @(negedge Clock);
    iStart = 1'b1; iBaseAddress = base; iLength = len;
    @(negedge Clock);
    iStart = 1'b0; iBaseAddress = 16'($urandom); iLength = 8'($urandom);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    @(negedge Clock);
    n_checks++;
    if ({oBusy, oReadEnable, oValid, oDone} !== 4'b0 || oReadAddress !== 16'h0 || oData !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b re=%b addr=%h data=%h valid=%b done=%b, want all 0",
               oBusy, oReadEnable, oReadAddress, oData, oValid, oDone);
    end
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_stream(input logic [15:0] base, input int len);
    iReady = 1'b1;
    start_burst(base, 8'(len));
    for (int c = 0; c <= len + 3; c++) begin
      logic [15:0] ea;
      logic [7:0]  ed;
      logic        e_re, e_v, e_done, e_busy;
      ea     = base + 16'(c - 1);
      ed     = ram_val(base + 16'(c - 2));
      e_re   = (c >= 1 && c <= len);
      e_v    = (c >= 2 && c <= len + 1);
      e_done = (c == len + 2);
      e_busy = (c <= len + 2);
      n_checks++;
      if (oReadEnable !== e_re || (e_re && oReadAddress !== ea)) begin
        n_fail++;
        $display("FAIL stream_read base=%h c=%0d: re=%b addr=%h, want re=%b addr=%h",
                 base, c, oReadEnable, oReadAddress, e_re, ea);
      end
      n_checks++;
      if (oValid !== e_v || (e_v && oData !== ed)) begin
        n_fail++;
        $display("FAIL stream_data base=%h c=%0d: valid=%b data=%h, want valid=%b data=%h",
                 base, c, oValid, oData, e_v, ed);
      end
      n_checks++;
      if (oDone !== e_done || oBusy !== e_busy) begin
        n_fail++;
        $display("FAIL stream_status base=%h c=%0d: done=%b busy=%b, want done=%b busy=%b",
                 base, c, oDone, oBusy, e_done, e_busy);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_random_ready(input logic [15:0] base, input int len);
    int          pops = 0, issued = 0, cyc = 0, last_pop = -10;
    logic        done_seen = 1'b0, pv = 1'b0, pr = 1'b0;
    logic [7:0]  pd = 8'h0;
    logic [15:0] next_addr = base;
    start_burst(base, 8'(len));
    while (!done_seen && cyc < 400) begin
      iReady = 1'($urandom_range(0, 1));
      if (oReadEnable) begin
        n_checks++;
        if (oReadAddress !== next_addr) begin
          n_fail++;
          $display("FAIL rand_addr: addr=%h, want %h", oReadAddress, next_addr);
        end
        next_addr++;
        issued++;
      end
      n_checks++;
      if (issued - pops > 2) begin
        n_fail++;
        $display("FAIL rand_credit: %0d words outstanding, want at most 2", issued - pops);
      end
      if (pv && !pr) begin
        n_checks++;
        if (oValid !== 1'b1 || oData !== pd) begin
          n_fail++;
          $display("FAIL rand_stable: valid=%b data=%h, want valid=1 data=%h", oValid, oData, pd);
        end
      end
      if (oDone) begin
        n_checks++;
        if (last_pop != cyc - 1 || pops != len) begin
          n_fail++;
          $display("FAIL rand_done: done at %0d after %0d pops (last pop %0d), want %0d pops",
                   cyc, pops, last_pop, len);
        end
        done_seen = 1'b1;
      end
      if (oValid && iReady) begin
        n_checks++;
        if (oData !== ram_val(base + 16'(pops))) begin
          n_fail++;
          $display("FAIL rand_data pop %0d: data=%h, want %h", pops, oData, ram_val(base + 16'(pops)));
        end
        pops++;
        last_pop = cyc;
      end
      pv = oValid; pr = iReady; pd = oData;
      cyc++;
      @(negedge Clock);
    end
    n_checks++;
    if (!done_seen || issued != len) begin
      n_fail++;
      $display("FAIL rand_end: done_seen=%b issued=%0d, want 1 and %0d", done_seen, issued, len);
    end
  endtask

  task automatic test_stall();
    logic [15:0] base;
    int          reads = 0, pops = 0, cyc = 0;
    logic        done_seen = 1'b0;
    base   = 16'($urandom);
    iReady = 1'b0;
    start_burst(base, 8'd8);
    for (int c = 0; c < 10; c++) begin
      if (oReadEnable) reads++;
      @(negedge Clock);
    end
    n_checks++;
    if (reads != 2 || oReadEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_reads: reads=%0d re=%b, want 2 and 0", reads, oReadEnable);
    end
    n_checks++;
    if (oValid !== 1'b1 || oData !== ram_val(base)) begin
      n_fail++;
      $display("FAIL stall_head: valid=%b data=%h, want 1 %h", oValid, oData, ram_val(base));
    end
    iReady = 1'b1;
    while (!done_seen && cyc < 100) begin
      if (oDone) done_seen = 1'b1;
      if (oValid) begin
        n_checks++;
        if (oData !== ram_val(base + 16'(pops))) begin
          n_fail++;
          $display("FAIL stall_data pop %0d: data=%h, want %h", pops, oData, ram_val(base + 16'(pops)));
        end
        pops++;
      end
      cyc++;
      @(negedge Clock);
    end
    n_checks++;
    if (!done_seen || pops != 8) begin
      n_fail++;
      $display("FAIL stall_end: done_seen=%b pops=%0d, want 1 and 8", done_seen, pops);
    end
  endtask

  task automatic test_empty();
    iReady = 1'b1;
    start_burst(16'h1234, 8'd0);
    n_checks++;
    if (oBusy !== 1'b1 || oDone !== 1'b1 || oReadEnable !== 1'b0 || oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done: busy=%b done=%b re=%b valid=%b, want 1 1 0 0",
               oBusy, oDone, oReadEnable, oValid);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clock);
      n_checks++;
      if (oBusy !== 1'b0 || oDone !== 1'b0 || oReadEnable !== 1'b0 || oValid !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_idle c=%0d: busy=%b done=%b re=%b valid=%b, want all 0",
                 c, oBusy, oDone, oReadEnable, oValid);
      end
    end
  endtask

  task automatic test_busy_ignored();
    logic [15:0] base;
    int          pops = 0, cyc = 0;
    logic        done_seen = 1'b0;
    base   = 16'($urandom);
    iReady = 1'b1;
    start_burst(base, 8'd3);
    while (!done_seen && cyc < 50) begin
      iStart = (cyc == 1);
      if (cyc == 1) begin iBaseAddress = base + 16'h0100; iLength = 8'd9; end
      if (oValid) begin
        n_checks++;
        if (oData !== ram_val(base + 16'(pops))) begin
          n_fail++;
          $display("FAIL ignored_data pop %0d: data=%h, want %h", pops, oData, ram_val(base + 16'(pops)));
        end
        pops++;
      end
      if (oDone) begin
        done_seen = 1'b1;
        iStart = 1'b1; iLength = 8'd5;
      end
      cyc++;
      @(negedge Clock);
    end
    iStart = 1'b0;
    n_checks++;
    if (!done_seen || pops != 3) begin
      n_fail++;
      $display("FAIL ignored_end: done_seen=%b pops=%0d, want 1 and 3", done_seen, pops);
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (oBusy !== 1'b0 || oReadEnable !== 1'b0) begin
        n_fail++;
        $display("FAIL ignored_idle c=%0d: busy=%b re=%b, want 0 0", c, oBusy, oReadEnable);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_reset_mid();
    iReady = 1'b1;
    start_burst(16'($urandom), 8'd8);
    repeat (4) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if ({oBusy, oReadEnable, oValid, oDone} !== 4'b0 || oReadAddress !== 16'h0 || oData !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b re=%b addr=%h data=%h valid=%b done=%b, want all 0",
               oBusy, oReadEnable, oReadAddress, oData, oValid, oDone);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      if (c == 2) Reset = 1'b0;
      n_checks++;
      if (oDone !== 1'b0 || oBusy !== 1'b0 || oValid !== 1'b0 || oReadEnable !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_quiet c=%0d: done=%b busy=%b valid=%b re=%b, want all 0",
                 c, oDone, oBusy, oValid, oReadEnable);
      end
    end
    test_stream(16'($urandom), 5);
  endtask

  initial begin
    Reset = 1'b1; iStart = 1'b0; iReady = 1'b0; iBaseAddress = '0; iLength = '0;
    test_reset();
    test_stream(16'h0010, 4);
    test_stream(16'hFFFE, 4);
    test_stream(16'hFFFF, 1);
    for (int i = 0; i < 3; i++) test_stream(16'($urandom), int'($urandom_range(1, 20)));
    test_random_ready(16'h0040, 6);
    for (int i = 0; i < 3; i++) test_random_ready(16'($urandom), int'($urandom_range(1, 12)));
    test_stall();
    test_empty();
    test_busy_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
